// File: rtl/hyperram_lb_arbiter_if.sv
// rtl/hyperram_lb_arbiter_if.sv - local-bus register port between the arbiter and the HyperRAM controller
interface hyperram_lb_arbiter_if;
    logic        lb_wr;
    logic        lb_rd;
    logic [31:0] lb_addr;
    logic [31:0] lb_wr_d;
    logic [31:0] lb_rd_d;
    logic        lb_rd_rdy;
    logic        hr_busy;

    modport master (
        output lb_wr, lb_rd, lb_addr, lb_wr_d,
        input  lb_rd_d, lb_rd_rdy, hr_busy
    );

    modport slave (
        input  lb_wr, lb_rd, lb_addr, lb_wr_d,
        output lb_rd_d, lb_rd_rdy, hr_busy
    );
endinterface

// File: rtl/hyperram_lb_arbiter.sv
// rtl/hyperram_lb_arbiter.sv - two-port round-robin arbiter driving HyperRAM controller register accesses
module hyperram_lb_arbiter #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rq0_req_i,
    input  logic        rq0_we_i,
    input  logic [31:0] rq0_addr_i,
    input  logic [31:0] rq0_wdata_i,
    output logic        rq0_done_o,
    output logic        rq0_err_o,
    output logic [31:0] rq0_rdata_o,
    input  logic        rq1_req_i,
    input  logic        rq1_we_i,
    input  logic [31:0] rq1_addr_i,
    input  logic [31:0] rq1_wdata_i,
    output logic        rq1_done_o,
    output logic        rq1_err_o,
    output logic [31:0] rq1_rdata_o,
    hyperram_lb_arbiter_if.master lb,
    output logic        owner_o,
    output logic        active_o
);
    localparam int WW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [31:0] REG_ADDR = 32'h10;
    localparam logic [31:0] REG_DATA = 32'h14;
    localparam logic [31:0] REG_CMD  = 32'h1c;
    localparam logic [31:0] CMD_WR   = 32'h1;
    localparam logic [31:0] CMD_RD   = 32'h4;

    typedef enum logic [2:0] {
        S_IDLE, S_SET_ADDR, S_SET_DATA, S_CMD, S_WAIT_BUSY, S_RD_REQ, S_RD_WAIT, S_DONE
    } state_t;

    state_t          state_q;
    logic            owner_q;
    logic            last_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [WW-1:0]   wait_q;
    logic [TW-1:0]   tmo_q;
    logic [1:0]      done_q;
    logic [1:0]      err_q;
    logic [31:0]     rdata0_q;
    logic [31:0]     rdata1_q;
    logic            lb_wr_q;
    logic            lb_rd_q;
    logic [31:0]     lb_addr_q;
    logic [31:0]     lb_wr_d_q;

    logic            gnt_d;
    logic [1:0]      owner_hot;

    // Contention goes to whoever was not served last; last_q resets to 1 so port 0 wins first.
    always_comb begin
        gnt_d = 1'b0;
        if (rq0_req_i && rq1_req_i) begin
            gnt_d = ~last_q;
        end else if (rq1_req_i) begin
            gnt_d = 1'b1;
        end
    end

    assign owner_hot = owner_q ? 2'b10 : 2'b01;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wait_q    <= '0;
            tmo_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            lb_wr_q   <= 1'b0;
            lb_rd_q   <= 1'b0;
            lb_addr_q <= '0;
            lb_wr_d_q <= '0;
        end else begin
            // Bus strobes and completion flags are registered alongside the state they belong to.
            lb_wr_q   <= 1'b0;
            lb_rd_q   <= 1'b0;
            lb_addr_q <= '0;
            lb_wr_d_q <= '0;
            done_q    <= '0;
            err_q     <= '0;
            case (state_q)
                S_IDLE: begin
                    if (rq0_req_i || rq1_req_i) begin
                        owner_q   <= gnt_d;
                        last_q    <= gnt_d;
                        we_q      <= gnt_d ? rq1_we_i    : rq0_we_i;
                        addr_q    <= gnt_d ? rq1_addr_i  : rq0_addr_i;
                        wdata_q   <= gnt_d ? rq1_wdata_i : rq0_wdata_i;
                        lb_wr_q   <= 1'b1;
                        lb_addr_q <= REG_ADDR;
                        lb_wr_d_q <= gnt_d ? rq1_addr_i : rq0_addr_i;
                        state_q   <= S_SET_ADDR;
                    end
                end
                S_SET_ADDR: begin
                    lb_wr_q <= 1'b1;
                    if (we_q) begin
                        lb_addr_q <= REG_DATA;
                        lb_wr_d_q <= wdata_q;
                        state_q   <= S_SET_DATA;
                    end else begin
                        lb_addr_q <= REG_CMD;
                        lb_wr_d_q <= CMD_RD;
                        state_q   <= S_CMD;
                    end
                end
                S_SET_DATA: begin
                    lb_wr_q   <= 1'b1;
                    lb_addr_q <= REG_CMD;
                    lb_wr_d_q <= CMD_WR;
                    state_q   <= S_CMD;
                end
                S_CMD: begin
                    wait_q  <= '0;
                    tmo_q   <= '0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (wait_q < WW'(SETTLE)) wait_q <= wait_q + WW'(1);
                    if (tmo_q != TW'(TIMEOUT)) tmo_q <= tmo_q + TW'(1);
                    // hr_busy is ignored until the controller has had SETTLE cycles to raise it.
                    if (wait_q >= WW'(SETTLE) && !lb.hr_busy) begin
                        if (we_q) begin
                            done_q  <= owner_hot;
                            state_q <= S_DONE;
                        end else begin
                            lb_rd_q   <= 1'b1;
                            lb_addr_q <= REG_DATA;
                            state_q   <= S_RD_REQ;
                        end
                    end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
                        done_q  <= owner_hot;
                        err_q   <= owner_hot;
                        state_q <= S_DONE;
                    end
                end
                S_RD_REQ: begin
                    if (lb.lb_rd_rdy) begin
                        if (owner_q) rdata1_q <= lb.lb_rd_d;
                        else         rdata0_q <= lb.lb_rd_d;
                        done_q  <= owner_hot;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (tmo_q != TW'(TIMEOUT)) tmo_q <= tmo_q + TW'(1);
                    if (lb.lb_rd_rdy) begin
                        if (owner_q) rdata1_q <= lb.lb_rd_d;
                        else         rdata0_q <= lb.lb_rd_d;
                        done_q  <= owner_hot;
                        state_q <= S_DONE;
                    end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
                        done_q  <= owner_hot;
                        err_q   <= owner_hot;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rq0_done_o  = done_q[0];
    assign rq1_done_o  = done_q[1];
    assign rq0_err_o   = err_q[0];
    assign rq1_err_o   = err_q[1];
    assign rq0_rdata_o = rdata0_q;
    assign rq1_rdata_o = rdata1_q;
    assign owner_o     = owner_q;
    assign active_o    = (state_q != S_IDLE);
    assign lb.lb_wr    = lb_wr_q;
    assign lb.lb_rd    = lb_rd_q;
    assign lb.lb_addr  = lb_addr_q;
    assign lb.lb_wr_d  = lb_wr_d_q;
endmodule

// File: tb/tb_hyperram_lb_arbiter.sv
// tb/tb_hyperram_lb_arbiter.sv - scoreboard bench for hyperram_lb_arbiter
module tb_hyperram_lb_arbiter;
    logic        clk;
    logic        reset;
    logic        rq0_req, rq0_we, rq1_req, rq1_we;
    logic [31:0] rq0_addr, rq0_wdata, rq1_addr, rq1_wdata;
    logic        rq0_done, rq0_err, rq1_done, rq1_err;
    logic [31:0] rq0_rdata, rq1_rdata;
    logic        owner, active;

    hyperram_lb_arbiter_if lbif ();

    hyperram_lb_arbiter #(.SETTLE(4), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .rq0_req_i(rq0_req), .rq0_we_i(rq0_we), .rq0_addr_i(rq0_addr), .rq0_wdata_i(rq0_wdata),
        .rq0_done_o(rq0_done), .rq0_err_o(rq0_err), .rq0_rdata_o(rq0_rdata),
        .rq1_req_i(rq1_req), .rq1_we_i(rq1_we), .rq1_addr_i(rq1_addr), .rq1_wdata_i(rq1_wdata),
        .rq1_done_o(rq1_done), .rq1_err_o(rq1_err), .rq1_rdata_o(rq1_rdata),
        .lb(lbif.master), .owner_o(owner), .active_o(active)
    );

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
    } lb_op_t;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] r0;
        logic [31:0] r1;
        int          lat;
    } done_t;

    lb_op_t      exp_lb[$];
    done_t       exp_done[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          grant_cyc = 0;
    logic        prev_act = 1'b0;
    logic [31:0] rd_m[2];
    int          rd_dly = 1;
    logic [31:0] rd_val = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Lb bus and completion monitor: pops expectations when the DUT presents an event.
    always @(negedge clk) begin
        if (active && !prev_act) grant_cyc = cyc - 1;
        prev_act = active;
        chk("lb_wr_rd_exclusive", {63'd0, lbif.lb_wr & lbif.lb_rd}, 64'd0);
        if (lbif.lb_wr || lbif.lb_rd) begin
            if (exp_lb.size() == 0) begin
                chk("unexpected_lb_op", {32'd0, lbif.lb_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                lb_op_t e;
                e = exp_lb.pop_front();
                chk("lb_op_kind", {63'd0, lbif.lb_rd}, {63'd0, e.rd});
                chk("lb_op_addr", {32'd0, lbif.lb_addr}, {32'd0, e.addr});
                chk("lb_op_data", {32'd0, lbif.lb_wr_d}, {32'd0, e.data});
            end
        end else begin
            chk("lb_idle_zero", {lbif.lb_addr, lbif.lb_wr_d}, 64'd0);
        end
        if (rq0_done || rq1_done) begin
            done_cnt++;
            chk("done_onehot", {63'd0, rq0_done & rq1_done}, 64'd0);
            if (exp_done.size() == 0) begin
                chk("unexpected_done", {62'd0, rq1_done, rq0_done}, 64'd0);
            end else begin
                done_t d;
                int    p;
                d = exp_done.pop_front();
                p = rq1_done ? 1 : 0;
                chk("done_port", 64'(p), 64'(d.port));
                chk("done_err", {63'd0, p == 1 ? rq1_err : rq0_err}, {63'd0, d.err});
                chk("done_other_err", {63'd0, p == 1 ? rq0_err : rq1_err}, 64'd0);
                chk("done_owner", {63'd0, owner}, 64'(d.port));
                chk("rdata0", {32'd0, rq0_rdata}, {32'd0, d.r0});
                chk("rdata1", {32'd0, rq1_rdata}, {32'd0, d.r1});
                chk("latency", 64'(cyc - grant_cyc), 64'(d.lat));
            end
        end else begin
            chk("err_without_done", {62'd0, rq1_err, rq0_err}, 64'd0);
        end
    end

    // Controller read-data responder: rdy in the lb_rd cycle (rd_dly=0) or the one after (rd_dly=1).
    initial begin
        lbif.lb_rd_rdy = 1'b0;
        lbif.lb_rd_d   = '0;
        forever begin
            @(posedge clk);
            #2;
            if (lbif.lb_rd) begin
                if (rd_dly == 0) begin
                    lbif.lb_rd_rdy = 1'b1;
                    lbif.lb_rd_d   = rd_val;
                    @(posedge clk);
                    #1;
                end else begin
                    @(posedge clk);
                    #1;
                    lbif.lb_rd_rdy = 1'b1;
                    lbif.lb_rd_d   = rd_val;
                    @(posedge clk);
                    #1;
                end
                lbif.lb_rd_rdy = 1'b0;
                lbif.lb_rd_d   = '0;
            end
        end
    end

    task automatic push_txn(int port, logic we, logic [31:0] addr, logic [31:0] wdata,
                            logic [31:0] rdv, logic err, int lat);
        done_t d;
        exp_lb.push_back('{1'b0, 32'h10, addr});
        if (we) begin
            exp_lb.push_back('{1'b0, 32'h14, wdata});
            exp_lb.push_back('{1'b0, 32'h1c, 32'h1});
        end else begin
            exp_lb.push_back('{1'b0, 32'h1c, 32'h4});
            if (!err) exp_lb.push_back('{1'b1, 32'h14, 32'h0});
            if (!err) rd_m[port] = rdv;
        end
        d.port = port; d.err = err; d.r0 = rd_m[0]; d.r1 = rd_m[1]; d.lat = lat;
        exp_done.push_back(d);
    endtask

    task automatic drive_req(int port, logic req, logic we, logic [31:0] addr, logic [31:0] wdata);
        if (port == 0) begin
            rq0_req = req; rq0_we = we; rq0_addr = addr; rq0_wdata = wdata;
        end else begin
            rq1_req = req; rq1_we = we; rq1_addr = addr; rq1_wdata = wdata;
        end
    endtask

    task automatic wait_done(int target, int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < target) chk("done_timeout", 64'(done_cnt), 64'(target));
    endtask

    task automatic run(int port, logic we, logic [31:0] addr, logic [31:0] wdata,
                       logic [31:0] rdv, int dly, logic err, int lat);
        int base;
        base = done_cnt;
        rd_val = rdv;
        rd_dly = dly;
        push_txn(port, we, addr, wdata, rdv, err, lat);
        @(posedge clk); #1;
        drive_req(port, 1'b1, we, addr, wdata);
        @(posedge clk); #1;
        drive_req(port, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_done(base + 1, 400);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_ctl"}, {56'd0, active, owner, lbif.lb_wr, lbif.lb_rd, rq0_done, rq1_done, rq0_err, rq1_err}, 64'd0);
        chk({tag, "_lb"}, {lbif.lb_addr, lbif.lb_wr_d}, 64'd0);
        chk({tag, "_rdata"}, {rq0_rdata, rq1_rdata}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1;
        lbif.hr_busy = 1'b0;
        drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        rd_m[0] = '0;
        rd_m[1] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        run(0, 1'b1, 32'h20, 32'hDEADBEEF, 32'h0, 1, 1'b0, 9);
        run(1, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1, 1'b0, 10);
        run(0, 1'b0, 32'h44, 32'h0, 32'h12345678, 0, 1'b0, 9);

        lbif.hr_busy = 1'b1;
        run(1, 1'b1, 32'h30, 32'hA5A5A5A5, 32'h0, 1, 1'b1, 4 + 255);
        lbif.hr_busy = 1'b0;
        run(0, 1'b1, 32'h34, 32'h0BADF00D, 32'h0, 1, 1'b0, 9);

        // hr_busy rises two cycles after CMD and stays up for 20 cycles.
        base = done_cnt;
        push_txn(1, 1'b1, 32'h50, 32'h11112222, 32'h0, 1'b0, 26);
        @(posedge clk); #1;
        drive_req(1, 1'b1, 1'b1, 32'h50, 32'h11112222);
        @(posedge clk); #1;
        drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(posedge clk);
        #1 lbif.hr_busy = 1'b1;
        repeat (20) @(posedge clk);
        #1 lbif.hr_busy = 1'b0;
        wait_done(base + 1, 100);

        // Reset in WAIT_BUSY: the three register writes happen, no completion follows.
        exp_lb.push_back('{1'b0, 32'h10, 32'h58});
        exp_lb.push_back('{1'b0, 32'h14, 32'h55AA55AA});
        exp_lb.push_back('{1'b0, 32'h1c, 32'h1});
        @(posedge clk); #1;
        drive_req(0, 1'b1, 1'b1, 32'h58, 32'h55AA55AA);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("active_in_wait_busy", {63'd0, active}, 64'd1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        rd_m[0] = '0;
        rd_m[1] = '0;
        repeat (5) @(posedge clk);
        chk("no_done_after_reset", 64'(exp_done.size()), 64'd0);
        run(0, 1'b1, 32'h60, 32'hCAFEF00D, 32'h0, 1, 1'b0, 9);

        // Both requesters held high from reset: grants alternate 0,1,0,1.
        @(posedge clk); #1 reset = 1'b1;
        drive_req(0, 1'b1, 1'b1, 32'h100, 32'hA0A0A0A0);
        drive_req(1, 1'b1, 1'b1, 32'h200, 32'hB1B1B1B1);
        rd_m[0] = '0;
        rd_m[1] = '0;
        for (int i = 0; i < 2; i++) begin
            push_txn(0, 1'b1, 32'h100, 32'hA0A0A0A0, 32'h0, 1'b0, 9);
            push_txn(1, 1'b1, 32'h200, 32'hB1B1B1B1, 32'h0, 1'b0, 9);
        end
        base = done_cnt;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_done(base + 4, 200);
        #1;
        drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);

        repeat (15) @(posedge clk);
        chk("exp_done_drained", 64'(exp_done.size()), 64'd0);
        chk("exp_lb_drained", 64'(exp_lb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
